mem_access_unit: RTL and testbench

MEM-stage data-memory access unit of the RV32IM pipeline, sitting between EX/MEM and the MEM/WB pipeline register. It turns a load/store request (address = EX/MEM ALU result, func3, store data) into a registered, byte-enabled word access on the data-memory bus. It stalls the pipeline through BUSYWAIT until the memory acknowledges. Its sign/zero-extended load result drives the MEM/WB register's MEM_DATA_MEM_READ_DATA input.

---
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access unit (byte-enabled word bus, stall until ACK)
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  DATA_MEM_READ,
    input  logic                  DATA_MEM_WRITE,
    input  logic [2:0]            FUNC3,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [31:0]           WRITE_DATA,
    output logic [31:0]           READ_DATA,
    output logic                  BUSYWAIT,
    output logic                  MISALIGNED,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-3:0] MEM_ADDRESS,
    output logic [31:0]           MEM_WRITEDATA,
    output logic [3:0]            MEM_BYTEEN,
    input  logic [31:0]           MEM_READDATA,
    input  logic                  MEM_ACK
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t                state_q, state_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_byteen_q, mem_byteen_d;
    logic [31:0]           read_data_q, read_data_d;
    logic                  byte_q, byte_d;
    logic                  half_q, half_d;
    logic                  uns_q, uns_d;
    logic [1:0]            lo_q, lo_d;

    logic        byte_op, half_op, uns_op, req, misaligned, issue;
    logic [3:0]  st_byteen;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Undefined func3 encodings fall through to word access.
    assign byte_op    = (FUNC3 == 3'b000) || (FUNC3 == 3'b100);
    assign half_op    = (FUNC3 == 3'b001) || (FUNC3 == 3'b101);
    assign uns_op     = FUNC3[2] & ~FUNC3[1];
    assign req        = DATA_MEM_READ | DATA_MEM_WRITE;
    assign misaligned = req & ((half_op & ADDRESS[0]) |
                               (~byte_op & ~half_op & (ADDRESS[1:0] != 2'b00)));
    assign issue      = (state_q == IDLE) & req & ~misaligned;

    assign MISALIGNED    = (state_q == IDLE) & misaligned;
    assign BUSYWAIT      = issue | (state_q == ACCESS);
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;
    assign MEM_BYTEEN    = mem_byteen_q;
    assign READ_DATA     = read_data_q;

    always_comb begin
        st_byteen = 4'b1111;
        st_data   = WRITE_DATA;
        if (byte_op) begin
            st_byteen = 4'b0001 << ADDRESS[1:0];
            st_data   = {4{WRITE_DATA[7:0]}};
        end else if (half_op) begin
            st_byteen = 4'b0011 << {ADDRESS[1], 1'b0};
            st_data   = {2{WRITE_DATA[15:0]}};
        end
    end

    // Extension uses the op captured at issue, so it is independent of the live inputs.
    always_comb begin
        case (lo_q)
            2'd0:    ld_byte = MEM_READDATA[7:0];
            2'd1:    ld_byte = MEM_READDATA[15:8];
            2'd2:    ld_byte = MEM_READDATA[23:16];
            default: ld_byte = MEM_READDATA[31:24];
        endcase
        ld_half = lo_q[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];
        ld_ext  = MEM_READDATA;
        if (byte_q)
            ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
        else if (half_q)
            ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
    end

    always_comb begin
        state_d      = state_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_byteen_d = mem_byteen_q;
        read_data_d  = read_data_q;
        byte_d       = byte_q;
        half_d       = half_q;
        uns_d        = uns_q;
        lo_d         = lo_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d      = ACCESS;
                    mem_write_d  = DATA_MEM_WRITE;
                    mem_read_d   = ~DATA_MEM_WRITE;
                    mem_addr_d   = ADDRESS[ADDR_WIDTH-1:2];
                    mem_wdata_d  = st_data;
                    mem_byteen_d = DATA_MEM_WRITE ? st_byteen : 4'b1111;
                    byte_d       = byte_op;
                    half_d       = half_op;
                    uns_d        = uns_op;
                    lo_d         = ADDRESS[1:0];
                end else if (misaligned) begin
                    read_data_d = 32'h0;
                end
            end
            ACCESS: begin
                if (MEM_ACK) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    read_data_d = mem_read_q ? ld_ext : 32'h0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_byteen_q <= 4'h0;
            read_data_q  <= 32'h0;
            byte_q       <= 1'b0;
            half_q       <= 1'b0;
            uns_q        <= 1'b0;
            lo_q         <= 2'b00;
        end else begin
            state_q      <= state_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_byteen_q <= mem_byteen_d;
            read_data_q  <= read_data_d;
            byte_q       <= byte_d;
            half_q       <= half_d;
            uns_q        <= uns_d;
            lo_q         <= lo_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a behavioural model
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        DATA_MEM_READ = 1'b0;
    logic        DATA_MEM_WRITE = 1'b0;
    logic [2:0]  FUNC3 = 3'b010;
    logic [31:0] ADDRESS = 32'h0;
    logic [31:0] WRITE_DATA = 32'h0;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [29:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [3:0]  MEM_BYTEEN;
    logic [31:0] MEM_READDATA = 32'h0;
    logic        MEM_ACK = 1'b0;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int rd_issues = 0;
    int wr_issues = 0;
    int last_rd_cyc = 0;
    int wr_rise_cyc = 0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .DATA_MEM_READ(DATA_MEM_READ), .DATA_MEM_WRITE(DATA_MEM_WRITE),
        .FUNC3(FUNC3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BYTEEN(MEM_BYTEEN),
        .MEM_READDATA(MEM_READDATA), .MEM_ACK(MEM_ACK)
    );

    always #5 CLK = ~CLK;

    // Bus monitor: counts issued strobes and remembers when they happened.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (MEM_READ && !prev_rd) rd_issues = rd_issues + 1;
        if (MEM_READ) last_rd_cyc = cyc;
        if (MEM_WRITE && !prev_wr) begin
            wr_issues = wr_issues + 1;
            wr_rise_cyc = cyc;
        end
        prev_rd = MEM_READ;
        prev_wr = MEM_WRITE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int lane;
        int v;
        lane = int'(addr % 4);
        case (f3)
            3'd0, 3'd4: begin
                v = int'((word >> (8 * lane)) & 32'd255);
                if (f3 == 3'd0 && v > 127) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = int'((word >> (8 * lane)) & 32'd65535);
                if (f3 == 3'd1 && v > 32767) v = v - 65536;
            end
            default: v = int'(word);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_byteen(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = size_of(f3);
        if (n == 1) return 32'(1 << (addr % 4));
        if (n == 2) return 32'(3 << (addr % 4));
        return 32'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n;
        n = size_of(f3);
        if (n == 1) return (wd & 32'hFF) * 32'h01010101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    task automatic sample;
        @(negedge CLK);
        #1;
    endtask

    // Runs one MEM-stage instruction starting just after a rising edge; returns just after
    // the edge where the pipeline advances, with the request removed.
    task automatic op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] word, input int waits);
        int rd0;
        int wr0;
        int bw;
        logic mis;
        rd0 = rd_issues;
        wr0 = wr_issues;
        mis = (addr % size_of(f3)) != 0;
        DATA_MEM_READ = rd;
        DATA_MEM_WRITE = wr;
        FUNC3 = f3;
        ADDRESS = addr;
        WRITE_DATA = wd;
        #1;
        check("misaligned_flag", {31'd0, MISALIGNED}, {31'd0, mis});
        if (mis) begin
            check("misaligned_busy", {31'd0, BUSYWAIT}, 32'd0);
            @(posedge CLK);
            #1;
            DATA_MEM_READ = 1'b0;
            DATA_MEM_WRITE = 1'b0;
            check("misaligned_rdata", READ_DATA, 32'h0);
            sample;
            check("misaligned_strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
            check("misaligned_issues", 32'(rd_issues - rd0 + wr_issues - wr0), 32'd0);
            @(posedge CLK);
            #1;
            return;
        end
        bw = 0;
        sample;
        bw = bw + int'(BUSYWAIT);
        @(posedge CLK);
        sample;
        check("strobe_access", {30'd0, MEM_READ, MEM_WRITE}, {30'd0, rd & ~wr, wr});
        check("mem_address", {2'b00, MEM_ADDRESS}, addr >> 2);
        check("byteen", {28'd0, MEM_BYTEEN}, wr ? ref_byteen(f3, addr) : 32'hF);
        if (wr) check("writedata", MEM_WRITEDATA, ref_wdata(f3, wd));
        for (int i = 0; i <= waits; i++) begin
            bw = bw + int'(BUSYWAIT);
            check("strobe_held", {30'd0, MEM_READ, MEM_WRITE}, {30'd0, rd & ~wr, wr});
            if (i == waits) begin
                MEM_ACK = 1'b1;
                MEM_READDATA = word;
            end
            @(posedge CLK);
            #1;
            if (i < waits) sample;
        end
        MEM_ACK = 1'b0;
        MEM_READDATA = $urandom;
        sample;
        check("done_busy", {31'd0, BUSYWAIT}, 32'd0);
        check("done_strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
        check("busy_cycles", 32'(bw), 32'(waits + 2));
        check("issue_count", {rd_issues - rd0, wr_issues - wr0},
              {32'(rd & ~wr), 32'(wr)});
        if (rd) check("read_data", READ_DATA, wr ? 32'h0 : ref_load(f3, addr, word));
        @(posedge CLK);
        #1;
        DATA_MEM_READ = 1'b0;
        DATA_MEM_WRITE = 1'b0;
    endtask

    initial begin
        logic [2:0] ld_f3 [8];
        logic [2:0] rf3;
        logic rrd;
        logic rwr;
        int r;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        #2;
        check("reset_outputs", {READ_DATA[15:0], 10'd0, BUSYWAIT, MISALIGNED, MEM_READ, MEM_WRITE,
              MEM_BYTEEN[1:0]}, 32'd0);
        check("reset_bus", MEM_WRITEDATA | {2'b00, MEM_ADDRESS} | READ_DATA, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("idle_busy", {31'd0, BUSYWAIT}, 32'd0);

        op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 0);
        op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 1);
        op(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0);
        op(0, 1, 3'b001, 32'h202, 32'h12345678, 32'h0, 1);
        op(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF7F01, 0);
        op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
        op(1, 0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 0);
        op(0, 1, 3'b001, 32'h203, 32'hAAAA5555, 32'h0, 0);
        op(1, 0, 3'b010, 32'h104, 32'h0, 32'h13579BDF, 0);

        // Reset in the middle of an access, then a stray ACK.
        DATA_MEM_READ = 1'b1;
        FUNC3 = 3'b010;
        ADDRESS = 32'h108;
        @(posedge CLK);
        sample;
        check("rst_pre_strobe", {31'd0, MEM_READ}, 32'd1);
        RESET = 1'b1;
        DATA_MEM_READ = 1'b0;
        #1;
        check("rst_async_strobe", {31'd0, MEM_READ}, 32'd0);
        check("rst_async_rdata", READ_DATA, 32'h0);
        check("rst_busy", {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        MEM_ACK = 1'b1;
        MEM_READDATA = 32'h55AA55AA;
        @(posedge CLK);
        #1;
        MEM_ACK = 1'b0;
        sample;
        check("stray_ack_rdata", READ_DATA, 32'h0);
        check("stray_ack_state", {30'd0, BUSYWAIT, MEM_READ}, 32'd0);
        @(posedge CLK);
        #1;

        // Back-to-back load then store.
        op(1, 0, 3'b010, 32'h300, 32'h0, 32'h01234567, 0);
        op(0, 1, 3'b010, 32'h304, 32'h89ABCDEF, 32'h0, 0);
        check("b2b_gap", 32'(wr_rise_cyc - last_rd_cyc), 32'd3);

        // Read and write together: the write wins.
        op(1, 1, 3'b010, 32'h400, 32'hFEEDFACE, 32'h77777777, 1);

        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 9));
            rrd = (r < 5) || (r == 9);
            rwr = (r >= 5);
            rf3 = rwr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 7)];
            op(rrd, rwr, rf3, $urandom & 32'hFFF, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
